// File: rtl/multi_timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer.
// Channel state encoding and prescaler width calculation.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    function automatic int pcnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Shared prescaler: counts 0..DIV-1 and emits a one-cycle tick on the last phase.
// tick_clear restarts the phase and overrides pause.
module timer_prescaler
    import multi_timer_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_clear,
    input  logic pause,
    output logic tick
);

    localparam int W = pcnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] pcnt;
    logic [W-1:0] pcnt_nxt;

    always_comb begin
        pcnt_nxt = pcnt;
        if (tick_clear) begin
            pcnt_nxt = '0;
        end else if (!pause) begin
            pcnt_nxt = (pcnt == LAST) ? '0 : pcnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt_nxt;
        end
    end

    assign tick = (pcnt == LAST) && !pause && !tick_clear;

endmodule

// File: rtl/multi_timer.sv
// N-channel countdown timer on a shared prescaled tick.
// Each channel runs one-shot or auto-reload with a sticky expiry flag.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_HZ  = 25_000_000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_clear,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       ack,
    input  logic [NUM_CH-1:0]       reload_mode,
    input  logic [NUM_CH*CNT_W-1:0] duration,
    output logic                    tick,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       expire_pulse,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
        $error("multi_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("multi_timer: NUM_CH must be 1..16");
    end

    timer_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_clear(tick_clear),
        .pause     (pause),
        .tick      (tick)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state;
        ch_state_t        state_nxt;
        logic [CNT_W-1:0] rem;
        logic [CNT_W-1:0] rem_nxt;
        logic [CNT_W-1:0] rld;
        logic [CNT_W-1:0] rld_nxt;
        logic [CNT_W-1:0] dur;
        logic             mode;
        logic             mode_nxt;
        logic             exp_q;
        logic             exp_nxt;
        logic             pls;
        logic             pls_nxt;
        logic             run_tick;

        assign dur      = duration[i*CNT_W +: CNT_W];
        assign run_tick = tick && (state == RUN) && (rem != '0);

        // Expiry outranks a coincident ack, so ack sits in the last branch.
        always_comb begin
            state_nxt = state;
            rem_nxt   = rem;
            rld_nxt   = rld;
            mode_nxt  = mode;
            exp_nxt   = exp_q;
            pls_nxt   = 1'b0;
            if (stop[i]) begin
                state_nxt = IDLE;
                rem_nxt   = '0;
                exp_nxt   = 1'b0;
            end else if (start[i]) begin
                rld_nxt  = dur;
                mode_nxt = reload_mode[i];
                rem_nxt  = dur;
                if (dur == '0) begin
                    state_nxt = DONE;
                    exp_nxt   = 1'b1;
                    pls_nxt   = 1'b1;
                end else begin
                    state_nxt = RUN;
                    exp_nxt   = 1'b0;
                end
            end else if (run_tick && rem == ONE) begin
                exp_nxt = 1'b1;
                pls_nxt = 1'b1;
                if (mode) begin
                    rem_nxt = rld;
                end else begin
                    rem_nxt   = '0;
                    state_nxt = DONE;
                end
            end else begin
                if (run_tick) begin
                    rem_nxt = rem - ONE;
                end
                if (ack[i]) begin
                    exp_nxt = 1'b0;
                    if (state == DONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                rem   <= '0;
                rld   <= '0;
                mode  <= 1'b0;
                exp_q <= 1'b0;
                pls   <= 1'b0;
            end else begin
                state <= state_nxt;
                rem   <= rem_nxt;
                rld   <= rld_nxt;
                mode  <= mode_nxt;
                exp_q <= exp_nxt;
                pls   <= pls_nxt;
            end
        end

        assign remaining[i*CNT_W +: CNT_W] = rem;
        assign busy[i]         = (state == RUN);
        assign expired[i]      = exp_q;
        assign expire_pulse[i] = pls;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with DIV=10, four 8-bit channels.
// Expected values are hand-derived from cycle counts after each start edge.
module tb_multi_timer;

    logic        clk;
    logic        rst_n;
    logic        tick_clear;
    logic        pause;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [3:0]  ack;
    logic [3:0]  reload_mode;
    logic [31:0] duration;
    logic        tick;
    logic [3:0]  busy;
    logic [3:0]  expired;
    logic [3:0]  expire_pulse;
    logic [31:0] remaining;

    int checks;
    int failures;
    int npulse;
    int found;
    int tickseen;

    multi_timer #(
        .NUM_CH (4),
        .CLK_HZ (10),
        .TICK_HZ(1),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_clear  (tick_clear),
        .pause       (pause),
        .start       (start),
        .stop        (stop),
        .ack         (ack),
        .reload_mode (reload_mode),
        .duration    (duration),
        .tick        (tick),
        .busy        (busy),
        .expired     (expired),
        .expire_pulse(expire_pulse),
        .remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        tick_clear  = 1'b0;
        pause       = 1'b0;
        start       = '0;
        stop        = '0;
        ack         = '0;
        reload_mode = '0;
        duration    = '0;
        step();
        step();
        rst_n = 1'b1;
        step();

        // mid-run reset
        duration[7:0] = 8'd5;
        start[0] = 1'b1;
        step();
        start = '0;
        check("pre_rst_busy", {28'd0, busy}, 32'h1);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("rst_rem", remaining, 32'h0);
        check("rst_busy", {28'd0, busy}, 32'h0);
        check("rst_exp", {28'd0, expired}, 32'h0);
        check("rst_pls", {28'd0, expire_pulse}, 32'h0);
        check("rst_tick", {31'd0, tick}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // one-shot, duration 3, aligned start
        duration[7:0] = 8'd3;
        start[0] = 1'b1;
        tick_clear = 1'b1;
        step();
        start = '0;
        tick_clear = 1'b0;
        check("os_load", {24'd0, remaining[7:0]}, 32'd3);
        check("os_busy", {31'd0, busy[0]}, 32'd1);
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 9) check("os_tick9", {31'd0, tick}, 32'd1);
            if (k == 10) check("os_tick10", {31'd0, tick}, 32'd0);
            if (k == 10) check("os_rem10", {24'd0, remaining[7:0]}, 32'd2);
            if (k == 20) check("os_rem20", {24'd0, remaining[7:0]}, 32'd1);
            if (k == 29) check("os_pls29", {31'd0, expire_pulse[0]}, 32'd0);
            if (k == 30) begin
                check("os_pls30", {31'd0, expire_pulse[0]}, 32'd1);
                check("os_rem30", {24'd0, remaining[7:0]}, 32'd0);
                check("os_busy30", {31'd0, busy[0]}, 32'd0);
                check("os_exp30", {31'd0, expired[0]}, 32'd1);
            end
            if (k == 31) begin
                check("os_pls31", {31'd0, expire_pulse[0]}, 32'd0);
                check("os_exp31", {31'd0, expired[0]}, 32'd1);
            end
        end
        ack[0] = 1'b1;
        step();
        ack = '0;
        check("os_ack", {31'd0, expired[0]}, 32'd0);

        // auto-reload, duration 2
        duration[15:8] = 8'd2;
        reload_mode[1] = 1'b1;
        start[1] = 1'b1;
        tick_clear = 1'b1;
        step();
        start = '0;
        tick_clear = 1'b0;
        npulse = 0;
        for (int k = 1; k <= 41; k++) begin
            ack[1] = (k == 40);
            step();
            ack = '0;
            if (expire_pulse[1]) npulse++;
            if (k == 20) begin
                check("ar_pls20", {31'd0, expire_pulse[1]}, 32'd1);
                check("ar_rem20", {24'd0, remaining[15:8]}, 32'd2);
                check("ar_busy20", {31'd0, busy[1]}, 32'd1);
                check("ar_exp20", {31'd0, expired[1]}, 32'd1);
            end
            if (k == 21) check("ar_pls21", {31'd0, expire_pulse[1]}, 32'd0);
            if (k == 30) check("ar_rem30", {24'd0, remaining[15:8]}, 32'd1);
            if (k == 40) begin
                check("ar_pls40", {31'd0, expire_pulse[1]}, 32'd1);
                check("ack_vs_reload", {31'd0, expired[1]}, 32'd1);
            end
        end
        check("ar_npulse", npulse, 32'd2);
        ack[1] = 1'b1;
        step();
        ack = '0;
        check("ar_ack", {31'd0, expired[1]}, 32'd0);
        check("ar_ack_busy", {31'd0, busy[1]}, 32'd1);
        stop[1] = 1'b1;
        step();
        stop = '0;
        check("ar_stop_rem", {24'd0, remaining[15:8]}, 32'd0);
        check("ar_stop_exp", {31'd0, expired[1]}, 32'd0);
        check("ar_stop_busy", {31'd0, busy[1]}, 32'd0);
        npulse = 0;
        repeat (45) begin
            step();
            if (expire_pulse[1]) npulse++;
        end
        check("ar_no_pulse", npulse, 32'd0);

        // zero duration, then restart from DONE
        duration[23:16] = 8'd0;
        start[2] = 1'b1;
        step();
        start = '0;
        check("z_exp", {31'd0, expired[2]}, 32'd1);
        check("z_pls", {31'd0, expire_pulse[2]}, 32'd1);
        check("z_busy", {31'd0, busy[2]}, 32'd0);
        check("z_rem", {24'd0, remaining[23:16]}, 32'd0);
        step();
        check("z_pls2", {31'd0, expire_pulse[2]}, 32'd0);
        check("z_busy2", {31'd0, busy[2]}, 32'd0);
        duration[23:16] = 8'd4;
        start[2] = 1'b1;
        step();
        start = '0;
        check("dn_restart_exp", {31'd0, expired[2]}, 32'd0);
        check("dn_restart_rem", {24'd0, remaining[23:16]}, 32'd4);
        check("dn_restart_busy", {31'd0, busy[2]}, 32'd1);
        stop[2] = 1'b1;
        step();
        stop = '0;

        // pause for 37 cycles mid-count
        duration[31:24] = 8'd5;
        start[3] = 1'b1;
        tick_clear = 1'b1;
        step();
        start = '0;
        tick_clear = 1'b0;
        repeat (15) step();
        check("p_rem_pre", {24'd0, remaining[31:24]}, 32'd4);
        pause = 1'b1;
        tickseen = 0;
        repeat (37) begin
            step();
            if (tick) tickseen++;
        end
        check("p_rem_hold", {24'd0, remaining[31:24]}, 32'd4);
        check("p_no_tick", tickseen, 32'd0);
        pause = 1'b0;
        found = 0;
        for (int k = 53; k <= 120; k++) begin
            step();
            if (expire_pulse[3] && found == 0) found = k;
        end
        check("p_expiry_cycle", found, 32'd87);
        check("p_busy_end", {31'd0, busy[3]}, 32'd0);

        // start and stop together
        duration[7:0] = 8'd7;
        start[0] = 1'b1;
        stop[0] = 1'b1;
        step();
        start = '0;
        stop = '0;
        check("ss_busy", {31'd0, busy[0]}, 32'd0);
        check("ss_rem", {24'd0, remaining[7:0]}, 32'd0);

        // all four expire on the same tick
        duration = {8'd1, 8'd1, 8'd1, 8'd1};
        reload_mode = '0;
        start = 4'hF;
        tick_clear = 1'b1;
        step();
        start = '0;
        tick_clear = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) check("all_pls9", {28'd0, expire_pulse}, 32'h0);
            if (k == 10) begin
                check("all_pls10", {28'd0, expire_pulse}, 32'hF);
                check("all_exp10", {28'd0, expired}, 32'hF);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
